// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the regfile write-port arbiter: default starvation
// limit and the two arbitration state encodings.
package wb_arbiter_pkg;

  // Default number of cycles mul/div may wait before it is force-granted.
  localparam int WB_ARB_STARVE_LIMIT_DEF = 4;

  // Arbitration states: normal pipeline priority, or forced mul/div grant.
  typedef enum logic {
    WB_ARB_PIPE_PRIO = 1'b0,
    WB_ARB_MD_FORCE  = 1'b1
  } wb_arb_state_e;

endpackage

// File: rtl/wb_arb_stats.sv
// Optional statistics block for wb_arbiter: counts mul/div wait cycles and
// force-grants. Both counters wrap and are cleared by reset.
module wb_arb_stats (
  input  logic        clock,
  input  logic        reset,
  input  logic        wait_stb,
  input  logic        force_stb,
  output logic [31:0] stat_md_wait,
  output logic [31:0] stat_force
);

  // Wrapping event counters, synchronous active-low clear.
  always_ff @(posedge clock) begin
    if (!reset) begin
      stat_md_wait <= '0;
      stat_force   <= '0;
    end else begin
      if (wait_stb)  stat_md_wait <= stat_md_wait + 32'd1;
      if (force_stb) stat_force   <= stat_force + 32'd1;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Regfile write-port arbiter between the in-order pipeline writeback stream
// and the multi-cycle mul/div unit. The pipeline has priority; a starvation
// counter force-grants mul/div after STARVE_LIMIT consecutive wait cycles.
// The winning write is registered toward the regfile; rd == 0 writes are
// accepted but never raise the write enable.
//
// Handshake: a requester transfers in a cycle when its valid and ready are
// both high. Ready is only ever raised toward a valid requester, at most one
// ready is high per cycle, and readies depend only on the valids and
// registered state (never on write data). Both readies are low during reset.
//
// Optional build macro: WB_ARB_STATS_EN adds stat_md_wait_o / stat_force_o.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = WB_ARB_STARVE_LIMIT_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pipe_valid_i,
  input  logic [4:0]  pipe_rd_i,
  input  logic [63:0] pipe_wdata_i,
  output logic        pipe_ready_o,
  input  logic        md_valid_i,
  input  logic [4:0]  md_rd_i,
  input  logic [63:0] md_wdata_i,
  output logic        md_ready_o,
  output logic        wen_o,
  output logic [4:0]  rd_o,
  output logic [63:0] wdata_o,
  output logic        md_starved_o,
  output logic        dbg_state,
  output logic [3:0]  dbg_wait_cnt
`ifdef WB_ARB_STATS_EN
  ,
  output logic [31:0] stat_md_wait_o,
  output logic [31:0] stat_force_o
`endif
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  wb_arb_state_e state, state_next;
  logic [3:0]    wait_cnt, wait_cnt_next;
  logic          force_md;
  logic          pipe_xfer, md_xfer;

  // State register: arbitration state and starvation counter.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= WB_ARB_PIPE_PRIO;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  // Next state: count consecutive mul/div wait cycles, saturating at the
  // limit; reaching the limit selects the forced-grant state.
  always_comb begin
    wait_cnt_next = wait_cnt;
    if (!md_valid_i || md_xfer) begin
      wait_cnt_next = '0;
    end else if (wait_cnt < LIMIT) begin
      wait_cnt_next = wait_cnt + 4'd1;
    end
    state_next = (wait_cnt_next == LIMIT) ? WB_ARB_MD_FORCE : WB_ARB_PIPE_PRIO;
  end

  // Outputs: grant selection and ready handshakes, all gated off in reset.
  always_comb begin
    force_md     = reset && (state == WB_ARB_MD_FORCE) && md_valid_i;
    pipe_ready_o = reset && pipe_valid_i && !force_md;
    md_ready_o   = reset && md_valid_i && (force_md || !pipe_valid_i);
    md_starved_o = force_md;
    pipe_xfer    = pipe_valid_i && pipe_ready_o;
    md_xfer      = md_valid_i && md_ready_o;
  end

  // Writeback register: capture the winning write; rd == 0 suppresses wen.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wen_o   <= 1'b0;
      rd_o    <= '0;
      wdata_o <= '0;
    end else if (pipe_xfer) begin
      wen_o   <= (pipe_rd_i != 5'd0);
      rd_o    <= pipe_rd_i;
      wdata_o <= pipe_wdata_i;
    end else if (md_xfer) begin
      wen_o   <= (md_rd_i != 5'd0);
      rd_o    <= md_rd_i;
      wdata_o <= md_wdata_i;
    end else begin
      wen_o   <= 1'b0;
    end
  end

  assign dbg_state    = state;
  assign dbg_wait_cnt = wait_cnt;

`ifdef WB_ARB_STATS_EN
  logic wait_stb;
  logic force_stb;

  assign wait_stb  = reset && md_valid_i && !md_ready_o;
  assign force_stb = force_md;

  wb_arb_stats u_stats (
    .clock        (clock),
    .reset        (reset),
    .wait_stb     (wait_stb),
    .force_stb    (force_stb),
    .stat_md_wait (stat_md_wait_o),
    .stat_force   (stat_force_o)
  );
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed vectors with literal expectations plus a
// behavioural model (consecutive-wait count, write queue) checked every cycle.
module tb_wb_arbiter;

  localparam int LIMIT = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        pipe_valid_i = 1'b0;
  logic [4:0]  pipe_rd_i = '0;
  logic [63:0] pipe_wdata_i = '0;
  logic        pipe_ready_o;
  logic        md_valid_i = 1'b0;
  logic [4:0]  md_rd_i = '0;
  logic [63:0] md_wdata_i = '0;
  logic        md_ready_o;
  logic        wen_o;
  logic [4:0]  rd_o;
  logic [63:0] wdata_o;
  logic        md_starved_o;
  logic        dbg_state;
  logic [3:0]  dbg_wait_cnt;
`ifdef WB_ARB_STATS_EN
  logic [31:0] stat_md_wait_o;
  logic [31:0] stat_force_o;
`endif

  int total = 0;
  int bad = 0;

  // Scoreboard: expected regfile writes {rd, data}, oldest first.
  logic [68:0] exp_q[$];

  // Model state.
  bit          started = 1'b0;
  int          m_cnt = 0;
  logic        m_wen = 1'b0;
  logic [4:0]  m_rd = '0;
  logic [63:0] m_wdata = '0;

  wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clock        (clock),
    .reset        (reset),
    .pipe_valid_i (pipe_valid_i),
    .pipe_rd_i    (pipe_rd_i),
    .pipe_wdata_i (pipe_wdata_i),
    .pipe_ready_o (pipe_ready_o),
    .md_valid_i   (md_valid_i),
    .md_rd_i      (md_rd_i),
    .md_wdata_i   (md_wdata_i),
    .md_ready_o   (md_ready_o),
    .wen_o        (wen_o),
    .rd_o         (rd_o),
    .wdata_o      (wdata_o),
    .md_starved_o (md_starved_o),
    .dbg_state    (dbg_state),
    .dbg_wait_cnt (dbg_wait_cnt)
`ifdef WB_ARB_STATS_EN
    ,
    .stat_md_wait_o (stat_md_wait_o),
    .stat_force_o   (stat_force_o)
`endif
  );

  // Clock / reset block.
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update at the active edge: who wins, what gets written, how long
  // mul/div has been kept waiting.
  always @(posedge clock) begin
    bit f, g_p, g_md;
    started = 1'b1;
    if (!reset) begin
      m_cnt = 0; m_wen = 1'b0; m_rd = '0; m_wdata = '0;
    end else begin
      f    = md_valid_i && (m_cnt >= LIMIT);
      g_p  = pipe_valid_i && !f;
      g_md = md_valid_i && (f || !pipe_valid_i);
      if (g_p) begin
        m_wen = (pipe_rd_i != 0); m_rd = pipe_rd_i; m_wdata = pipe_wdata_i;
        if (pipe_rd_i != 0) exp_q.push_back({pipe_rd_i, pipe_wdata_i});
      end else if (g_md) begin
        m_wen = (md_rd_i != 0); m_rd = md_rd_i; m_wdata = md_wdata_i;
        if (md_rd_i != 0) exp_q.push_back({md_rd_i, md_wdata_i});
      end else begin
        m_wen = 1'b0;
      end
      if (!md_valid_i || g_md) m_cnt = 0;
      else if (m_cnt < LIMIT) m_cnt = m_cnt + 1;
    end
  end

  // Compare process: every cycle, mid-period.
  always @(negedge clock) begin
    bit f;
    logic [68:0] w;
    if (started) begin
      f = reset && md_valid_i && (m_cnt >= LIMIT);
      check("pipe_ready", pipe_ready_o, reset && pipe_valid_i && !f);
      check("md_ready", md_ready_o, reset && md_valid_i && (f || !pipe_valid_i));
      check("md_starved", md_starved_o, f);
      check("wen", wen_o, m_wen);
      check("rd", rd_o, m_rd);
      check("wdata", wdata_o, m_wdata);
      if (wen_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL wb_unexpected: got write rd=%0d data=%0h expected none", rd_o, wdata_o);
        end else begin
          w = exp_q.pop_front();
          check("wb_order", {rd_o, wdata_o}, w);
        end
      end
    end
  end

  // Driver: apply one cycle of inputs just after the edge, return mid-cycle.
  task automatic cyc(input logic rst, input logic pv, input logic [4:0] prd,
                     input logic [63:0] pd, input logic mv, input logic [4:0] mrd,
                     input logic [63:0] md);
    @(posedge clock);
    #1;
    reset = rst;
    pipe_valid_i = pv; pipe_rd_i = prd; pipe_wdata_i = pd;
    md_valid_i = mv; md_rd_i = mrd; md_wdata_i = md;
    @(negedge clock);
  endtask

  task automatic idle();
    cyc(1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
  endtask

  initial begin
    // Reset
    cyc(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    cyc(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    check("rst_wen", wen_o, 1'b0);
    check("rst_rd", rd_o, 5'd0);
    check("rst_wdata", wdata_o, 64'd0);
    check("rst_wait_cnt", dbg_wait_cnt, 4'd0);
    idle();

    // Pipe only
    cyc(1'b1, 1'b1, 5'd5, 64'h1234, 1'b0, 5'd0, 64'd0);
    check("pipe_only_ready", pipe_ready_o, 1'b1);
    check("pipe_only_md_ready", md_ready_o, 1'b0);
    idle();
    check("pipe_only_wen", wen_o, 1'b1);
    check("pipe_only_rd", rd_o, 5'd5);
    check("pipe_only_wdata", wdata_o, 64'h1234);
    idle();
    check("pipe_only_wen_drop", wen_o, 1'b0);
    check("pipe_only_rd_hold", rd_o, 5'd5);

    // Collision: pipe wins, mul/div follows when pipe drops
    cyc(1'b1, 1'b1, 5'd1, 64'h11, 1'b1, 5'd2, 64'h22);
    check("coll_pipe_ready", pipe_ready_o, 1'b1);
    check("coll_md_ready", md_ready_o, 1'b0);
    cyc(1'b1, 1'b0, 5'd0, 64'd0, 1'b1, 5'd2, 64'h22);
    check("coll_md_ready2", md_ready_o, 1'b1);
    check("coll_wr1_rd", rd_o, 5'd1);
    check("coll_wr1_wdata", wdata_o, 64'h11);
    idle();
    check("coll_wr2_wen", wen_o, 1'b1);
    check("coll_wr2_rd", rd_o, 5'd2);
    check("coll_wr2_wdata", wdata_o, 64'h22);

    // Fresh reset so the statistics start from zero
    cyc(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);

    // Starvation under continuous pipeline traffic
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b1, 5'd3, 64'(i), 1'b1, 5'd7, 64'h77);
      check("starve_md_wait", md_ready_o, 1'b0);
      check("starve_pipe_go", pipe_ready_o, 1'b1);
      check("starve_flag_lo", md_starved_o, 1'b0);
    end
    cyc(1'b1, 1'b1, 5'd3, 64'd4, 1'b1, 5'd7, 64'h77);
    check("force_md_ready", md_ready_o, 1'b1);
    check("force_pipe_ready", pipe_ready_o, 1'b0);
    check("force_flag", md_starved_o, 1'b1);
    check("force_wait_cnt", dbg_wait_cnt, 4'd4);
    cyc(1'b1, 1'b1, 5'd3, 64'd5, 1'b0, 5'd0, 64'd0);
    check("resume_pipe_ready", pipe_ready_o, 1'b1);
    check("resume_flag", md_starved_o, 1'b0);
    check("force_wr_rd", rd_o, 5'd7);
    check("force_wr_wdata", wdata_o, 64'h77);
`ifdef WB_ARB_STATS_EN
    check("stat_md_wait", stat_md_wait_o, 32'd4);
    check("stat_force", stat_force_o, 32'd1);
`endif
    idle();

    // x0 write: accepted, no write enable
    cyc(1'b1, 1'b0, 5'd0, 64'd0, 1'b1, 5'd0, 64'hFF);
    check("x0_md_ready", md_ready_o, 1'b1);
    idle();
    check("x0_wen", wen_o, 1'b0);
    check("x0_wdata", wdata_o, 64'hFF);

    // Reset mid-transfer
    cyc(1'b1, 1'b1, 5'd4, 64'h44, 1'b1, 5'd9, 64'h99);
    check("pre_rst_wait_cnt", dbg_wait_cnt, 4'd0);
    cyc(1'b0, 1'b1, 5'd4, 64'h44, 1'b1, 5'd9, 64'h99);
    check("rst_mid_pipe_ready", pipe_ready_o, 1'b0);
    check("rst_mid_md_ready", md_ready_o, 1'b0);
    check("rst_mid_wait_cnt_before", dbg_wait_cnt, 4'd1);
    idle();
    check("rst_mid_wen", wen_o, 1'b0);
    check("rst_mid_wait_cnt", dbg_wait_cnt, 4'd0);

    // Mixed traffic patterns, checked by the model each cycle
    for (int i = 0; i < 48; i++) begin
      logic pv, mv;
      pv = (i < 20) ? (i % 3 != 0) : 1'b1;
      mv = (i < 20) ? (i % 5 < 3) : (i % 9 != 8);
      cyc(1'b1, pv, 5'(i), 64'(i * 16'h0101), mv, 5'(i + 11), 64'(i * 32'h10001 + 1));
    end
    idle();
    idle();
    check("wb_queue_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
